multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Moore-style control sequencer for the multicycle variant of the MIPS core.
- Replaces the single-cycle combinational control unit.
- Steps each instruction through fetch / decode / execute / memory / writeback over 3-5 cycles on one shared memory.
- Drives every mux select and write enable of the multicycle datapath (PC, IR, register file, ALU, memory); stalls on a memory ready handshake.

Parameters:
- MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored (treated as 1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instruction[31:26] from the instruction register
- mem_ready  in  1  memory has completed the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero (beq)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  load instruction register
- MemtoReg  out  1  register write data select: 0 = ALUOut, 1 = MDR
- RegDst  out  1  write register select: 0 = rt, 1 = rd
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct decode
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump address
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode
- state_o  out  4  current state encoding, for debug and coverage

Behaviour:
- Reset
  - While rst is high at a clock edge, the next state is FETCH.
  - While rst is high, every output is forced to 0, including state_o = FETCH encoding 0.
  - Reset mid-instruction aborts the instruction; no write enable is asserted in the reset cycle.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
- Outputs not listed for a state are 0.
- FETCH
  - Asserts MemRead, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - IRWrite and PCWrite are asserted only when mem_ready = 1.
  - Go to DECODE on mem_ready, otherwise stay.
- DECODE
  - ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target into ALUOut).
  - Next state by opcode:
    - 0x00 -> EXEC
    - 0x23 or 0x2B -> MEMADR
    - 0x04 -> BRANCH
    - 0x02 -> JUMP
    - 0x08 -> ADDIEX
    - any other opcode -> FETCH, with illegal_op = 1 and instr_done = 1
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Go to MEMRD if opcode = 0x23, otherwise MEMWR.
- MEMRD: MemRead = 1, IorD = 1. Go to MEMWB on mem_ready, otherwise stay.
- MEMWB: RegWrite = 1, MemtoReg = 1, RegDst = 0, instr_done = 1. Go to FETCH.
- MEMWR
  - MemRead = 0, IorD = 1, MemWrite = 1 held high until mem_ready.
  - instr_done = 1 in the mem_ready cycle; then go to FETCH.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Go to RWB.
- RWB: RegWrite = 1, RegDst = 1, MemtoReg = 0, instr_done = 1. Go to FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01, instr_done = 1. Go to FETCH.
- JUMP: PCWrite = 1, PCSource = 10, instr_done = 1. Go to FETCH.
- ADDIEX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Go to ADDIWB.
- ADDIWB: RegWrite = 1, RegDst = 0, MemtoReg = 0, instr_done = 1. Go to FETCH.
- Latency with mem_ready tied high: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2 cycles.
- Each cycle of mem_ready = 0 in FETCH, MEMRD or MEMWR adds one cycle.
- Invariants
  - opcode is sampled only in DECODE and MEMADR; the IR is stable there.
  - MemRead and MemWrite are never both 1.
  - PCWrite and PCWriteCond are never both 1.
  - Unreachable encodings 12-15 go to FETCH with all outputs 0.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALUOp codes
  - ALUSrcB and PCSource select codes
  - the 4-bit state enum
- No sub-module: a single FSM, with next-state logic and output decode in separate always blocks.

Test Plan:
- rst = 1 for 2 cycles with mem_ready = 1 -> all outputs 0. After release, first cycle: state_o = 0, MemRead = 1, IRWrite = 1, PCWrite = 1, ALUSrcB = 01.
- opcode 0x23, mem_ready = 1 -> states 0, 1, 2, 3, 4. MEMWB: RegWrite = 1, MemtoReg = 1. instr_done pulses in cycle 5 only.
- opcode 0x2B, mem_ready low for 3 cycles in MEMWR -> MemWrite held 4 cycles. instr_done only in the mem_ready cycle. RegWrite never 1.
- Sequence 0x00, 0x04, 0x02, 0x08 -> latencies 4, 3, 3, 4 cycles.
  - BRANCH: PCWriteCond = 1, ALUOp = 01.
  - JUMP: PCSource = 10.
  - RWB: RegDst = 1.
- opcode 0x3F -> illegal_op = 1 in DECODE, then FETCH. No RegWrite, MemWrite or PCWrite beyond the fetch cycle.
- rst asserted while in MEMRD -> next cycle state_o = 0. No RegWrite in the cycle rst is high or after it. Fetch restarts cleanly.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, datapath select codes and control FSM state encoding
package mips_pkg;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_4      = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_t;
endpackage

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore control sequencer for the multicycle MIPS datapath
module multicycle_control_fsm
   import mips_pkg::*;
#(
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state_o
);
   state_t state, state_nx;
   logic rdy;
   assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;
   always_ff @(posedge clk)
      state <= rst ? S_FETCH : state_nx;
   always_comb begin
      state_nx = S_FETCH;
      case (state)
         S_FETCH:  state_nx = rdy ? S_DECODE : S_FETCH;
         S_DECODE: case (opcode)
                      OP_RTYPE:     state_nx = S_EXEC;
                      OP_LW, OP_SW: state_nx = S_MEMADR;
                      OP_BEQ:       state_nx = S_BRANCH;
                      OP_J:         state_nx = S_JUMP;
                      OP_ADDI:      state_nx = S_ADDIEX;
                      default:      state_nx = S_FETCH;
                   endcase
         S_MEMADR: state_nx = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_nx = rdy ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_nx = rdy ? S_FETCH : S_MEMWR;
         S_EXEC:   state_nx = S_RWB;
         S_ADDIEX: state_nx = S_ADDIWB;
         default:  state_nx = S_FETCH;
      endcase
   end
   // reset overrides the decode so no enable leaks while an instruction is aborted
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_B;
      ALUOp       = ALU_ADD;
      PCSource    = PCSRC_ALU;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
      state_o     = rst ? S_FETCH : state;
      if (!rst)
         case (state)
            S_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = SRCB_4;
               IRWrite = rdy;
               PCWrite = rdy;
            end
            S_DECODE: begin
               ALUSrcB    = SRCB_IMM_SH;
               illegal_op = !(opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
               instr_done = illegal_op;
            end
            S_MEMADR, S_ADDIEX: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            S_MEMWB: begin
               RegWrite   = 1'b1;
               MemtoReg   = 1'b1;
               instr_done = 1'b1;
            end
            S_MEMWR: begin
               IorD       = 1'b1;
               MemWrite   = 1'b1;
               instr_done = rdy;
            end
            S_EXEC: begin
               ALUSrcA = 1'b1;
               ALUOp   = ALU_FUNCT;
            end
            S_RWB: begin
               RegWrite   = 1'b1;
               RegDst     = 1'b1;
               instr_done = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOp       = ALU_SUB;
               PCWriteCond = 1'b1;
               PCSource    = PCSRC_ALUOUT;
               instr_done  = 1'b1;
            end
            S_JUMP: begin
               PCWrite    = 1'b1;
               PCSource   = PCSRC_JUMP;
               instr_done = 1'b1;
            end
            S_ADDIWB: begin
               RegWrite   = 1'b1;
               instr_done = 1'b1;
            end
            default: state_o = state;
         endcase
   end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: table-driven per-cycle checks through a scoreboard, plus latency and invariant runs
module tb_multicycle_control_fsm;
   typedef struct packed {
      logic [3:0] st;
      logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
      logic [1:0] srcb, aluop, pcsrc;
      logic done, ill;
   } outs_t;
   typedef struct {
      logic  rst;
      logic [5:0] op;
      logic  rdy;
      outs_t exp;
      string name;
   } vec_t;
   logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b1;
   logic [5:0] opcode = 6'h00;
   logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic instr_done, illegal_op;
   logic [3:0] state_o;
   int tests = 0, fails = 0;
   vec_t vecs[$];
   vec_t sb[$];
   multicycle_control_fsm #(.MEM_HANDSHAKE(1'b1)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op), .state_o(state_o)
   );
   always #5 clk = ~clk;
   // field order: pcw pcwc iord mrd mwr irw m2r rdst rw srca | srcb | aluop | pcsrc | done ill
   localparam logic [17:0] O_ZERO     = {10'b0000000000, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] O_FETCH    = {10'b1001010000, 2'b01, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] O_FSTALL   = {10'b0001000000, 2'b01, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] O_DECODE   = {10'b0000000000, 2'b11, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] O_ILLEGAL  = {10'b0000000000, 2'b11, 2'b00, 2'b00, 2'b11};
   localparam logic [17:0] O_ADDR     = {10'b0000000001, 2'b10, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] O_MEMRD    = {10'b0011000000, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] O_MEMWB    = {10'b0000001010, 2'b00, 2'b00, 2'b00, 2'b10};
   localparam logic [17:0] O_MEMWR    = {10'b0010100000, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] O_MEMWR_D  = {10'b0010100000, 2'b00, 2'b00, 2'b00, 2'b10};
   localparam logic [17:0] O_EXEC     = {10'b0000000001, 2'b00, 2'b10, 2'b00, 2'b00};
   localparam logic [17:0] O_RWB      = {10'b0000000110, 2'b00, 2'b00, 2'b00, 2'b10};
   localparam logic [17:0] O_BRANCH   = {10'b0100000001, 2'b00, 2'b01, 2'b01, 2'b10};
   localparam logic [17:0] O_JUMP     = {10'b1000000000, 2'b00, 2'b00, 2'b10, 2'b10};
   localparam logic [17:0] O_ADDIWB   = {10'b0000000010, 2'b00, 2'b00, 2'b00, 2'b10};
   function automatic outs_t mk(input logic [3:0] st, input logic [17:0] b);
      return {st, b};
   endfunction
   task automatic add(input logic r, input logic [5:0] op, input logic rdy, input logic [3:0] st,
                      input logic [17:0] b, input string name);
      vec_t v;
      v.rst = r; v.op = op; v.rdy = rdy; v.exp = mk(st, b); v.name = name;
      vecs.push_back(v);
   endtask
   function automatic outs_t got();
      return {state_o, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
              RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op};
   endfunction
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask
   initial begin
      logic [5:0] lat_ops [4];
      int lat_exp [4];
      logic [5:0] rnd_ops [8];
      int n;
      vec_t v;
      add(1, 6'h23, 1, 0, O_ZERO,    "reset0");
      add(1, 6'h23, 1, 0, O_ZERO,    "reset1");
      add(0, 6'h23, 1, 0, O_FETCH,   "lw_fetch");
      add(0, 6'h23, 1, 1, O_DECODE,  "lw_decode");
      add(0, 6'h23, 1, 2, O_ADDR,    "lw_memadr");
      add(0, 6'h23, 1, 3, O_MEMRD,   "lw_memrd");
      add(0, 6'h23, 1, 4, O_MEMWB,   "lw_memwb");
      add(0, 6'h2B, 1, 0, O_FETCH,   "sw_fetch");
      add(0, 6'h2B, 1, 1, O_DECODE,  "sw_decode");
      add(0, 6'h2B, 1, 2, O_ADDR,    "sw_memadr");
      add(0, 6'h2B, 0, 5, O_MEMWR,   "sw_wait0");
      add(0, 6'h2B, 0, 5, O_MEMWR,   "sw_wait1");
      add(0, 6'h2B, 0, 5, O_MEMWR,   "sw_wait2");
      add(0, 6'h2B, 1, 5, O_MEMWR_D, "sw_done");
      add(0, 6'h00, 1, 0, O_FETCH,   "r_fetch");
      add(0, 6'h00, 1, 1, O_DECODE,  "r_decode");
      add(0, 6'h00, 1, 6, O_EXEC,    "r_exec");
      add(0, 6'h00, 1, 7, O_RWB,     "r_rwb");
      add(0, 6'h04, 1, 0, O_FETCH,   "beq_fetch");
      add(0, 6'h04, 1, 1, O_DECODE,  "beq_decode");
      add(0, 6'h04, 1, 8, O_BRANCH,  "beq_branch");
      add(0, 6'h02, 1, 0, O_FETCH,   "j_fetch");
      add(0, 6'h02, 1, 1, O_DECODE,  "j_decode");
      add(0, 6'h02, 1, 9, O_JUMP,    "j_jump");
      add(0, 6'h08, 1, 0, O_FETCH,   "addi_fetch");
      add(0, 6'h08, 1, 1, O_DECODE,  "addi_decode");
      add(0, 6'h08, 1, 10, O_ADDR,   "addi_ex");
      add(0, 6'h08, 1, 11, O_ADDIWB, "addi_wb");
      add(0, 6'h3F, 1, 0, O_FETCH,   "ill_fetch");
      add(0, 6'h3F, 1, 1, O_ILLEGAL, "ill_decode");
      add(0, 6'h00, 0, 0, O_FSTALL,  "fstall0");
      add(0, 6'h00, 0, 0, O_FSTALL,  "fstall1");
      add(0, 6'h00, 1, 0, O_FETCH,   "fstall_go");
      add(0, 6'h00, 1, 1, O_DECODE,  "fstall_decode");
      add(0, 6'h00, 1, 6, O_EXEC,    "fstall_exec");
      add(0, 6'h00, 1, 7, O_RWB,     "fstall_rwb");
      add(0, 6'h23, 1, 0, O_FETCH,   "abort_fetch");
      add(0, 6'h23, 1, 1, O_DECODE,  "abort_decode");
      add(0, 6'h23, 1, 2, O_ADDR,    "abort_memadr");
      add(0, 6'h23, 0, 3, O_MEMRD,   "abort_memrd");
      add(1, 6'h23, 1, 0, O_ZERO,    "abort_rst");
      add(0, 6'h23, 1, 0, O_FETCH,   "restart_fetch");
      add(0, 6'h23, 1, 1, O_DECODE,  "restart_decode");
      add(0, 6'h23, 1, 2, O_ADDR,    "restart_memadr");
      add(0, 6'h23, 1, 3, O_MEMRD,   "restart_memrd");
      add(0, 6'h23, 1, 4, O_MEMWB,   "restart_memwb");
      foreach (vecs[i]) begin
         @(posedge clk); #1;
         rst = vecs[i].rst; opcode = vecs[i].op; mem_ready = vecs[i].rdy;
         sb.push_back(vecs[i]);
         @(negedge clk);
         v = sb.pop_front();
         check(v.name, 32'(got()), 32'(v.exp));
      end
      lat_ops = '{6'h00, 6'h04, 6'h02, 6'h08};
      lat_exp = '{4, 3, 3, 4};
      @(posedge clk); #1 rst = 1'b1; mem_ready = 1'b1;
      @(posedge clk); #1 rst = 1'b0; opcode = lat_ops[0];
      for (int k = 0; k < 4; k++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!instr_done && n < 20);
         check($sformatf("latency_op%0h", lat_ops[k]), 32'(n), 32'(lat_exp[k]));
         if (k < 3) opcode = lat_ops[k+1];
      end
      rnd_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h11};
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      for (int c = 0; c < 300; c++) begin
         opcode = rnd_ops[$urandom_range(7)];
         mem_ready = 1'($urandom_range(1));
         @(negedge clk);
         check("inv_mem_excl", 32'(MemRead & MemWrite), 32'd0);
         check("inv_pc_excl", 32'(PCWrite & PCWriteCond), 32'd0);
         check("inv_state_range", 32'(state_o > 4'd11), 32'd0);
         if (illegal_op)
            check("inv_illegal_decode", {28'd0, state_o}, 32'd1);
         @(posedge clk); #1;
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
